button_bank: RTL and testbench

- Parametrised N-channel push-button conditioner that replaces per-button debouncer instances in the maze and VGA tops.
- Each raw button input goes through a 2-flop synchroniser, a stability counter and an edge detector, producing a debounced level plus single-cycle press and release pulses.
- Compiles with optional hold-to-repeat so a held direction key steps the player continuously.
- Sits between board pins and maze_controller-class consumers.

---
 rtl/button_bank.sv | 118 +++++++++++
 tb/tb_button_bank.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// N-channel push-button conditioner: 2-flop synchroniser, stability counter and edge pulses per channel.
// Define BUTTON_BANK_REPEAT_EN to add hold-to-repeat press pulses.
module button_bank #(
  parameter int N_CH            = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] i_buttons,
  input  logic [N_CH-1:0] i_en,
  output logic [N_CH-1:0] o_level,
  output logic [N_CH-1:0] o_press,
  output logic [N_CH-1:0] o_release,
  output logic            o_any_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Per-channel state is carried by the level flop itself.
  localparam logic IDLE = 1'b0;
  localparam logic HELD = 1'b1;

  logic [N_CH-1:0] sync1_q, sync1_d;
  logic [N_CH-1:0] sync2_q, sync2_d;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] release_q, release_d;
  logic            any_press_q, any_press_d;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] rise, fall;

`ifdef BUTTON_BANK_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);
  localparam logic [RW-1:0] RDLY_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPER_LOAD = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0]   rcnt_q [N_CH];
  logic [RW-1:0]   rcnt_d [N_CH];
  logic [N_CH-1:0] rep_fire;
`endif

  always_comb begin
    sync1_d = i_buttons;
    sync2_d = sync1_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) level_d[i] = ~level_q[i];
        else                     cnt_d[i]   = cnt_q[i] + 1'b1;
      end
      rise[i] = (level_q[i] == IDLE) && (level_d[i] == HELD);
      fall[i] = (level_q[i] == HELD) && (level_d[i] == IDLE);

`ifdef BUTTON_BANK_REPEAT_EN
      // Counter runs regardless of i_en so the repeat phase survives a disable.
      rcnt_d[i]   = rcnt_q[i];
      rep_fire[i] = 1'b0;
      if (rise[i]) begin
        rcnt_d[i] = RDLY_LOAD;
      end else if ((level_q[i] == HELD) && (level_d[i] == HELD)) begin
        if (rcnt_q[i] == '0) begin
          rep_fire[i] = 1'b1;
          rcnt_d[i]   = RPER_LOAD;
        end else begin
          rcnt_d[i] = rcnt_q[i] - 1'b1;
        end
      end
      press_d[i] = (rise[i] | rep_fire[i]) & i_en[i];
`else
      press_d[i] = rise[i] & i_en[i];
`endif
      release_d[i] = fall[i] & i_en[i];
    end
    any_press_d = |press_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
`ifdef BUTTON_BANK_REPEAT_EN
        rcnt_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      any_press_q <= any_press_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= cnt_d[i];
`ifdef BUTTON_BANK_REPEAT_EN
        rcnt_q[i] <= rcnt_d[i];
`endif
      end
    end
  end

  assign o_level     = level_q;
  assign o_press     = press_q;
  assign o_release   = release_q;
  assign o_any_press = any_press_q;

endmodule

// File: tb/tb_button_bank.sv
// Randomised and directed bench for button_bank against a sample-window reference model.
module tb_button_bank;

  localparam int N_CH = 5;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
`ifdef BUTTON_BANK_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N_CH-1:0] btn, en;
  logic [N_CH-1:0] o_level, o_press, o_release;
  logic            o_any_press;

  button_bank #(
    .N_CH(N_CH), .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .i_buttons(btn), .i_en(en),
    .o_level(o_level), .o_press(o_press), .o_release(o_release), .o_any_press(o_any_press)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference: a channel flips once its last DEB synchronised samples all disagree with its level.
  logic [N_CH-1:0] m_s1, m_s2, m_level, m_press, m_rel;
  logic            m_any;
  logic            hist [N_CH][DEB];
  int              held [N_CH];

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_any = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      held[c] = 0;
      for (int k = 0; k < DEB; k++) hist[c][k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [N_CH-1:0] nl;
    bool_t: begin end
    nl = m_level;
    for (int c = 0; c < N_CH; c++) begin
      bit all_diff;
      for (int k = DEB - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = m_s2[c];
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) if (hist[c][k] == m_level[c]) all_diff = 1'b0;
      if (all_diff) nl[c] = ~m_level[c];
    end
    for (int c = 0; c < N_CH; c++) begin
      bit fire;
      if (nl[c] && !m_level[c]) held[c] = 0;
      else if (nl[c])           held[c]++;
      fire = nl[c] && ((!m_level[c]) ||
             (REP && held[c] >= RD && ((held[c] - RD) % RP) == 0));
      m_press[c] = fire && en[c];
      m_rel[c]   = !nl[c] && m_level[c] && en[c];
    end
    m_any   = |m_press;
    m_s2    = m_s1;
    m_s1    = btn;
    m_level = nl;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
    check("level",   16'(o_level),     16'(m_level));
    check("press",   16'(o_press),     16'(m_press));
    check("release", 16'(o_release),   16'(m_rel));
    check("any",     16'(o_any_press), 16'(m_any));
    check("excl",    16'(o_press & o_release), 16'h0);
  endtask

  task automatic async_reset_pulse(input int hold_cycles);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("rst_level", 16'(o_level), 16'h0);
    check("rst_press", 16'(o_press), 16'h0);
    check("rst_rel",   16'(o_release), 16'h0);
    check("rst_any",   16'(o_any_press), 16'h0);
    repeat (hold_cycles) cycle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) cycle();
  endtask

  int cnt;
  int thr;

  initial begin
    // 1. Reset with all buttons held
    rst = 1'b0; btn = '1; en = '1;
    model_reset();
    #1;
    check("t1_rst_level", 16'(o_level), 16'h0);
    check("t1_rst_press", 16'(o_press), 16'h0);
    wait_cycles(3);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check("t1_level", 16'(o_level), (k == 6) ? 16'h1f : 16'h0);
      check("t1_press", 16'(o_press), (k == 6) ? 16'h1f : 16'h0);
      check("t1_any",   16'(o_any_press), (k == 6) ? 16'h1 : 16'h0);
    end
    cycle();
    check("t1_press_once", 16'(o_press), 16'h0);

    // 2. Bounce on ch0
    btn[0] = 1'b0; wait_cycles(8);
    btn[0] = 1'b1; repeat (2) begin cycle(); check("t2_bounce", 16'(o_press[0]), 16'h0); end
    btn[0] = 1'b0; repeat (2) begin cycle(); check("t2_bounce", 16'(o_press[0]), 16'h0); end
    btn[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("t2_press", 16'(o_press[0]), (k == 6) ? 16'h1 : 16'h0);
    end
    check("t2_level", 16'(o_level[0]), 16'h1);

    // 3. Release/press with enable low, then high
    en[2] = 1'b0; btn[2] = 1'b0;
    repeat (8) begin cycle(); check("t3_rel_gated", 16'(o_release[2]), 16'h0); end
    check("t3_level_lo", 16'(o_level[2]), 16'h0);
    btn[2] = 1'b1;
    repeat (8) begin cycle(); check("t3_press_gated", 16'(o_press[2]), 16'h0); end
    check("t3_level_hi", 16'(o_level[2]), 16'h1);
    en[2] = 1'b1; btn[2] = 1'b0; cnt = 0;
    repeat (8) begin cycle(); cnt += int'(o_release[2]); end
    check("t3_rel_count", 16'(cnt), 16'h1);
    btn[2] = 1'b1; cnt = 0;
    repeat (8) begin cycle(); cnt += int'(o_press[2]); end
    check("t3_press_count", 16'(cnt), 16'h1);

    // 4. Simultaneous press on ch1 and ch4
    btn = '0; wait_cycles(20);
    btn[1] = 1'b1; btn[4] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("t4_press", 16'(o_press), (k == 6) ? 16'h12 : 16'h0);
      check("t4_any",   16'(o_any_press), (k == 6) ? 16'h1 : 16'h0);
    end

    // 5. Hold-to-repeat on ch3
    btn = '0; wait_cycles(20);
    btn[3] = 1'b1; wait_cycles(5); cnt = 0;
    repeat (30) begin cycle(); cnt += int'(o_press[3]); end
    check("t5_repeat_count", 16'(cnt), REP ? 16'd8 : 16'd1);
    btn[3] = 1'b0; wait_cycles(6);
    check("t5_level_fell", 16'(o_level[3]), 16'h0);
    cnt = 0;
    repeat (15) begin cycle(); cnt += int'(o_press[3]); end
    check("t5_no_trailing", 16'(cnt), 16'h0);

    // 6. Reset mid-count and mid-repeat
    btn[3] = 1'b1; wait_cycles(18);
    btn[0] = 1'b1; wait_cycles(4);
    async_reset_pulse(2);
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check("t6_press", 16'(o_press), (k == 6) ? 16'h09 : 16'h0);
    end

    // Randomised traffic with occasional asynchronous resets
    thr = 40;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) thr = ($urandom_range(0, 1) == 0) ? 3 : 40;
      for (int c = 0; c < N_CH; c++)
        if ($urandom_range(0, thr - 1) == 0) btn[c] = ~btn[c];
      if ($urandom_range(0, 15) == 0) en = N_CH'($urandom);
      if ($urandom_range(0, 699) == 0) async_reset_pulse(int'($urandom_range(0, 2)));
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
